// File: rtl/pc_eval_bp_if.sv
// EX-stage resolution, IF-stage lookup and redirect bundle for pc_eval_bp.
// master = pipeline side (drives EX/IF inputs), slave = evaluator.
// All outputs besides the lookup pair are registered inside the evaluator.
interface pc_eval_bp_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             i_Valid;
  logic             i_Br;
  logic [WIDTH-1:0] i_Br_PC;
  logic [WIDTH-1:0] i_PC;
  logic [WIDTH-1:0] i_ALU_rslt;
  logic [WIDTH-1:0] i_PPC;
  logic             i_NPC_Ctrl;
  logic [WIDTH-1:0] i_Lookup_PC;
  logic [WIDTH-1:0] o_Pred_PC;
  logic             o_Pred_Taken;
  logic [WIDTH-1:0] o_New_PC;
  logic             o_Flush;
  logic             o_PPC_Eq;
  logic [CNT_W-1:0] o_Mispred_Cnt;

  modport master (
    output i_Valid, i_Br, i_Br_PC, i_PC, i_ALU_rslt, i_PPC, i_NPC_Ctrl, i_Lookup_PC,
    input  o_Pred_PC, o_Pred_Taken, o_New_PC, o_Flush, o_PPC_Eq, o_Mispred_Cnt
  );

  modport slave (
    input  i_Valid, i_Br, i_Br_PC, i_PC, i_ALU_rslt, i_PPC, i_NPC_Ctrl, i_Lookup_PC,
    output o_Pred_PC, o_Pred_Taken, o_New_PC, o_Flush, o_PPC_Eq, o_Mispred_Cnt
  );
endinterface

// File: rtl/pc_eval_bp.sv
// EX-stage next-PC evaluator with a direct-mapped 2-bit-counter branch target table.
// Latency: lookup is combinational; redirect/flush/stats are registered, 1 cycle after resolution.
// No backpressure: the EX instruction arriving while o_Flush=1 is wrong-path and is dropped.
module pc_eval_bp #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int IDX_LSB = 2,
  parameter int CNT_W   = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  pc_eval_bp_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = WIDTH - IDX_LSB - IDX_W;
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  // Predictor table state
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [TAG_W-1:0] tag_d    [DEPTH];
  logic [WIDTH-1:0] target_q [DEPTH];
  logic [WIDTH-1:0] target_d [DEPTH];
  logic [1:0]       ctr_q    [DEPTH];
  logic [1:0]       ctr_d    [DEPTH];

  // Registered resolution outputs
  logic [WIDTH-1:0] new_pc_q, new_pc_d;
  logic             flush_q, flush_d;
  logic             ppc_eq_q, ppc_eq_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  // IF-stage lookup signals
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  // EX-stage resolution signals
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             ex_taken;
  logic             accept;
  logic [WIDTH-1:0] actual;
  logic             mis;

  assign lk_idx = bus.i_Lookup_PC[IDX_LSB +: IDX_W];
  assign lk_tag = bus.i_Lookup_PC[WIDTH-1 -: TAG_W];
  assign ex_idx = bus.i_Br_PC[IDX_LSB +: IDX_W];
  assign ex_tag = bus.i_Br_PC[WIDTH-1 -: TAG_W];

  // Same-cycle prediction from pre-update table contents (no write bypass)
  always_comb begin
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && ctr_q[lk_idx][1];
  end

  assign bus.o_Pred_Taken  = lk_taken;
  assign bus.o_Pred_PC     = lk_taken ? target_q[lk_idx] : (bus.i_Lookup_PC + PC_STEP);
  assign bus.o_New_PC      = new_pc_q;
  assign bus.o_Flush       = flush_q;
  assign bus.o_PPC_Eq      = ppc_eq_q;
  assign bus.o_Mispred_Cnt = mis_cnt_q;

  // Resolve the EX instruction: actual next PC, mispredict, and the redirect/stat updates
  always_comb begin
    accept   = bus.i_Valid && !flush_q;
    ex_taken = !bus.i_NPC_Ctrl;
    actual   = bus.i_NPC_Ctrl ? bus.i_PC : bus.i_ALU_rslt;
    mis      = (actual != bus.i_PPC);
    ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    new_pc_d  = new_pc_q;
    ppc_eq_d  = ppc_eq_q;
    mis_cnt_d = mis_cnt_q;
    flush_d   = 1'b0;
    if (accept) begin
      new_pc_d = actual;
      flush_d  = mis;
      ppc_eq_d = !mis;
      if (mis && (mis_cnt_q != {CNT_W{1'b1}})) begin
        mis_cnt_d = mis_cnt_q + CNT_W'(1);
      end
    end
  end

  // Train the table for accepted branches; wrong-path instructions leave it untouched
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (accept && bus.i_Br) begin
      if (ex_hit) begin
        if (ex_taken) begin
          ctr_d[ex_idx]    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
          target_d[ex_idx] = bus.i_ALU_rslt;
        end else begin
          ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = bus.i_ALU_rslt;
        ctr_d[ex_idx]    = 2'b10;
      end
    end
  end

  // Control state: reset wins over any same-cycle resolution or training
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q   <= '0;
      new_pc_q  <= '0;
      flush_q   <= 1'b0;
      ppc_eq_q  <= 1'b1;
      mis_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      valid_q   <= valid_d;
      new_pc_q  <= new_pc_d;
      flush_q   <= flush_d;
      ppc_eq_q  <= ppc_eq_d;
      mis_cnt_q <= mis_cnt_d;
      ctr_q     <= ctr_d;
    end
  end

  // Tag/target payload needs no reset: it is only observed behind a valid bit
  always_ff @(posedge i_clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end
endmodule

// File: tb/tb_pc_eval_bp.sv
// Self-checking bench for pc_eval_bp: directed scenarios plus randomized traffic
// checked against a behavioural model of the predictor table and redirect logic.
// Counter width is reduced so saturation is reachable in a short run.
module tb_pc_eval_bp;
  localparam int W     = 32;
  localparam int D     = 16;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  pc_eval_bp_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  pc_eval_bp #(.WIDTH(W), .DEPTH(D), .IDX_LSB(2), .CNT_W(CW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural model
  bit          m_vld [D];
  int unsigned m_tag [D];
  logic [31:0] m_tgt [D];
  int          m_ctr [D];
  logic [31:0] m_new_pc;
  bit          m_flush;
  bit          m_eq;
  int          m_cnt;

  // Lookup observed/expected in the most recent cycle (sampled before its edge)
  bit          obs_tk, exp_tk;
  logic [31:0] obs_ppc, exp_ppc;

  function automatic void model_lookup(input logic [31:0] pc, output bit tk, output logic [31:0] npc);
    int unsigned idx = (pc >> 2) % D;
    int unsigned tag = pc >> 6;
    bit hit = m_vld[idx] && (m_tag[idx] == tag);
    tk  = hit && (m_ctr[idx] >= 2);
    npc = tk ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic void model_step(input bit rst, input bit valid, input bit br, input bit npc_ctrl,
                                     input logic [31:0] br_pc, input logic [31:0] pc,
                                     input logic [31:0] alu, input logic [31:0] ppc);
    int unsigned idx = (br_pc >> 2) % D;
    int unsigned tag = br_pc >> 6;
    logic [31:0] act;
    bit hit;
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        m_vld[i] = 0;
        m_ctr[i] = 1;
      end
      m_new_pc = 0; m_flush = 0; m_eq = 1; m_cnt = 0;
    end else if (m_flush || !valid) begin
      m_flush = 0;
    end else begin
      act      = npc_ctrl ? pc : alu;
      m_new_pc = act;
      m_flush  = (act != ppc);
      m_eq     = (act == ppc);
      if (act != ppc && m_cnt < CMAX) m_cnt++;
      if (br) begin
        hit = m_vld[idx] && (m_tag[idx] == tag);
        if (hit && !npc_ctrl) begin
          m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          m_tgt[idx] = alu;
        end else if (hit) begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end else if (!npc_ctrl) begin
          m_vld[idx] = 1; m_tag[idx] = tag; m_tgt[idx] = alu; m_ctr[idx] = 2;
        end
      end
    end
  endfunction

  // One clock: drive inputs, sample the lookup before the edge, advance model after it
  task automatic cycle(input bit rst, input bit valid, input bit br, input bit npc_ctrl,
                       input logic [31:0] br_pc, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] ppc, input logic [31:0] lpc);
    i_rst = rst;
    bus.i_Valid = valid; bus.i_Br = br; bus.i_NPC_Ctrl = npc_ctrl;
    bus.i_Br_PC = br_pc; bus.i_PC = pc; bus.i_ALU_rslt = alu; bus.i_PPC = ppc;
    bus.i_Lookup_PC = lpc;
    #1;
    model_lookup(lpc, exp_tk, exp_ppc);
    obs_tk  = bus.o_Pred_Taken;
    obs_ppc = bus.o_Pred_PC;
    @(posedge i_clk);
    model_step(rst, valid, br, npc_ctrl, br_pc, pc, alu, ppc);
    #1;
  endtask

  task automatic idle(input logic [31:0] lpc);
    cycle(0, 0, 0, 1, 32'h0, 32'h4, 32'h0, 32'h4, lpc);
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 1, 0, 4, 0, 4, 32'h100);
    cycle(1, 0, 0, 1, 0, 4, 0, 4, 32'h100);
    idle(32'h100);
    checks++; if (obs_tk !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%0b exp=0", obs_tk); end
    checks++; if (obs_ppc !== 32'h104) begin failures++; $display("FAIL reset_pred_pc got=%h exp=00000104", obs_ppc); end
    checks++; if (bus.o_Flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b exp=0", bus.o_Flush); end
    checks++; if (bus.o_PPC_Eq !== 1'b1) begin failures++; $display("FAIL reset_ppc_eq got=%0b exp=1", bus.o_PPC_Eq); end
    checks++; if (bus.o_Mispred_Cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.o_Mispred_Cnt); end
    checks++; if (bus.o_New_PC !== 32'h0) begin failures++; $display("FAIL reset_new_pc got=%h exp=0", bus.o_New_PC); end
    idle(32'hFFFF_FFFC);
    checks++; if (obs_ppc !== 32'h0) begin failures++; $display("FAIL lookup_wrap got=%h exp=00000000", obs_ppc); end
  endtask

  task automatic test_alloc_and_flush_ignore;
    // Taken branch predicted not-taken: allocate and redirect
    cycle(0, 1, 1, 0, 32'h100, 32'h104, 32'h200, 32'h104, 32'h100);
    checks++; if (obs_ppc !== 32'h104) begin failures++; $display("FAIL no_bypass got=%h exp=00000104", obs_ppc); end
    checks++; if (bus.o_Flush !== 1'b1) begin failures++; $display("FAIL alloc_flush got=%0b exp=1", bus.o_Flush); end
    checks++; if (bus.o_New_PC !== 32'h200) begin failures++; $display("FAIL alloc_new_pc got=%h exp=00000200", bus.o_New_PC); end
    checks++; if (bus.o_PPC_Eq !== 1'b0) begin failures++; $display("FAIL alloc_ppc_eq got=%0b exp=0", bus.o_PPC_Eq); end
    checks++; if (bus.o_Mispred_Cnt !== 8'd1) begin failures++; $display("FAIL alloc_cnt got=%0d exp=1", bus.o_Mispred_Cnt); end
    // Wrong-path instruction during the flush cycle is dropped
    cycle(0, 1, 1, 0, 32'h100, 32'h104, 32'h998, 32'h104, 32'h100);
    checks++; if (obs_tk !== 1'b1 || obs_ppc !== 32'h200) begin failures++; $display("FAIL alloc_lookup got=%0b/%h exp=1/00000200", obs_tk, obs_ppc); end
    checks++; if (bus.o_Flush !== 1'b0) begin failures++; $display("FAIL ignore_flush got=%0b exp=0", bus.o_Flush); end
    checks++; if (bus.o_Mispred_Cnt !== 8'd1) begin failures++; $display("FAIL ignore_cnt got=%0d exp=1", bus.o_Mispred_Cnt); end
    checks++; if (bus.o_New_PC !== 32'h200 || bus.o_PPC_Eq !== 1'b0) begin failures++; $display("FAIL ignore_hold got=%h/%0b exp=00000200/0", bus.o_New_PC, bus.o_PPC_Eq); end
    idle(32'h100);
    checks++; if (obs_ppc !== 32'h200) begin failures++; $display("FAIL ignore_table got=%h exp=00000200", obs_ppc); end
  endtask

  task automatic test_counter_training;
    cycle(0, 1, 1, 1, 32'h100, 32'h104, 32'h200, 32'h104, 32'h100);
    checks++; if (bus.o_Flush !== 1'b0 || bus.o_PPC_Eq !== 1'b1) begin failures++; $display("FAIL nt1 got=%0b/%0b exp=0/1", bus.o_Flush, bus.o_PPC_Eq); end
    checks++; if (bus.o_New_PC !== 32'h104) begin failures++; $display("FAIL nt1_new_pc got=%h exp=00000104", bus.o_New_PC); end
    cycle(0, 1, 1, 1, 32'h100, 32'h104, 32'h200, 32'h104, 32'h100);
    checks++; if (obs_tk !== 1'b0 || obs_ppc !== 32'h104) begin failures++; $display("FAIL ctr01_lookup got=%0b/%h exp=0/00000104", obs_tk, obs_ppc); end
    checks++; if (bus.o_Flush !== 1'b0) begin failures++; $display("FAIL nt2_flush got=%0b exp=0", bus.o_Flush); end
    // Counter now 00: one taken brings it to 01 (still not taken), a second to 10
    cycle(0, 1, 1, 0, 32'h100, 32'h104, 32'h200, 32'h200, 32'h100);
    checks++; if (bus.o_Flush !== 1'b0 || bus.o_New_PC !== 32'h200) begin failures++; $display("FAIL tk_ok got=%0b/%h exp=0/00000200", bus.o_Flush, bus.o_New_PC); end
    idle(32'h100);
    checks++; if (obs_ppc !== 32'h104) begin failures++; $display("FAIL ctr_floor got=%h exp=00000104", obs_ppc); end
    cycle(0, 1, 1, 0, 32'h100, 32'h104, 32'h240, 32'h240, 32'h100);
    idle(32'h100);
    checks++; if (obs_tk !== 1'b1 || obs_ppc !== 32'h240) begin failures++; $display("FAIL ctr_up got=%0b/%h exp=1/00000240", obs_tk, obs_ppc); end
  endtask

  task automatic test_alias;
    cycle(0, 1, 1, 0, 32'h140, 32'h144, 32'h300, 32'h300, 32'h140);
    checks++; if (obs_ppc !== 32'h144) begin failures++; $display("FAIL alias_pre got=%h exp=00000144", obs_ppc); end
    idle(32'h100);
    checks++; if (obs_tk !== 1'b0 || obs_ppc !== 32'h104) begin failures++; $display("FAIL alias_evict got=%0b/%h exp=0/00000104", obs_tk, obs_ppc); end
    idle(32'h140);
    checks++; if (obs_tk !== 1'b1 || obs_ppc !== 32'h300) begin failures++; $display("FAIL alias_hit got=%0b/%h exp=1/00000300", obs_tk, obs_ppc); end
  endtask

  task automatic test_random;
    logic [31:0] bpc, alu, act, ppc, lpc;
    bit v, br, nc;
    for (int n = 0; n < 2000; n++) begin
      bpc = 32'h1000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      lpc = 32'h1000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      alu = 32'h2000 + (32'($urandom_range(0, 7)) << 2);
      v   = ($urandom_range(0, 9) < 8);
      br  = ($urandom_range(0, 9) < 7);
      nc  = $urandom_range(0, 1);
      act = nc ? bpc + 32'd4 : alu;
      case ($urandom_range(0, 3))
        0, 1:    ppc = act;
        2:       ppc = bpc + 32'd4;
        default: ppc = alu;
      endcase
      cycle(0, v, br, nc, bpc, bpc + 32'd4, alu, ppc, lpc);
      checks++; if (obs_tk !== exp_tk || obs_ppc !== exp_ppc) begin failures++; $display("FAIL rnd_lookup n=%0d pc=%h got=%0b/%h exp=%0b/%h", n, lpc, obs_tk, obs_ppc, exp_tk, exp_ppc); end
      checks++; if (bus.o_Flush !== m_flush || bus.o_New_PC !== m_new_pc || bus.o_PPC_Eq !== m_eq) begin
        failures++; $display("FAIL rnd_resolve n=%0d got=%0b/%h/%0b exp=%0b/%h/%0b", n, bus.o_Flush, bus.o_New_PC, bus.o_PPC_Eq, m_flush, m_new_pc, m_eq);
      end
      checks++; if (bus.o_Mispred_Cnt !== CW'(m_cnt)) begin failures++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, bus.o_Mispred_Cnt, m_cnt); end
    end
    idle(32'h0);
  endtask

  task automatic test_saturate;
    cycle(1, 0, 0, 1, 0, 4, 0, 4, 32'h0);
    for (int i = 1; i <= CMAX + 10; i++) begin
      cycle(0, 1, 0, 1, 32'h500, 32'h504, 32'h0, 32'h600, 32'h0);
      idle(32'h0);
      if (i == 100) begin
        checks++; if (bus.o_Mispred_Cnt !== 8'd100) begin failures++; $display("FAIL cnt_mid got=%0d exp=100", bus.o_Mispred_Cnt); end
      end
    end
    checks++; if (bus.o_Mispred_Cnt !== 8'hFF) begin failures++; $display("FAIL cnt_sat got=%0d exp=255", bus.o_Mispred_Cnt); end
    cycle(0, 1, 0, 1, 32'h500, 32'h504, 32'h0, 32'h600, 32'h0);
    checks++; if (bus.o_Flush !== 1'b1 || bus.o_Mispred_Cnt !== 8'hFF) begin failures++; $display("FAIL cnt_hold got=%0b/%0d exp=1/255", bus.o_Flush, bus.o_Mispred_Cnt); end
    idle(32'h0);
  endtask

  task automatic test_reset_priority;
    cycle(0, 1, 1, 0, 32'h100, 32'h104, 32'h200, 32'h200, 32'h100);
    // Reset in the same cycle as a mispredicting, allocating branch
    cycle(1, 1, 1, 0, 32'h180, 32'h184, 32'h700, 32'h184, 32'h100);
    checks++; if (obs_tk !== 1'b1) begin failures++; $display("FAIL pre_reset_hit got=%0b exp=1", obs_tk); end
    i_rst = 1'b0;
    checks++; if (bus.o_Flush !== 1'b0 || bus.o_Mispred_Cnt !== 8'd0) begin failures++; $display("FAIL rst_prio got=%0b/%0d exp=0/0", bus.o_Flush, bus.o_Mispred_Cnt); end
    checks++; if (bus.o_PPC_Eq !== 1'b1 || bus.o_New_PC !== 32'h0) begin failures++; $display("FAIL rst_prio_out got=%0b/%h exp=1/0", bus.o_PPC_Eq, bus.o_New_PC); end
    idle(32'h180);
    checks++; if (obs_tk !== 1'b0 || obs_ppc !== 32'h184) begin failures++; $display("FAIL rst_no_alloc got=%0b/%h exp=0/00000184", obs_tk, obs_ppc); end
    for (int i = 0; i < D; i++) begin
      idle(32'h100 + 32'(i * 4));
      checks++; if (obs_tk !== 1'b0) begin failures++; $display("FAIL rst_invalid idx=%0d got=%0b exp=0", i, obs_tk); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alloc_and_flush_ignore();
    test_counter_training();
    test_alias();
    test_random();
    test_saturate();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
